// File: rtl/sobel_edge_binarize.sv
// sobel_edge_binarize: sits after the sobel operator. Tracks the raster
// position of each gradient pixel, forces the BORDER-wide ring to zero,
// thresholds interior pixels to 0 / all-ones, pulses frameDone with the last
// pixel of a frame, and reports the frame's edge-pixel count.
//
// Optional feature: define SOBEL_EDGE_COUNT_EN to build the edge accumulator.
// Without it, edgeCount is tied to 0.
//
// Handshake: a pixel is accepted on a rising edge when inputValid=1 and
// either the FSM is ACTIVE or frameStart=1. There is no backpressure. Every
// accepted pixel produces exactly one result with outputValid=1 on the next
// cycle. Pixels that are not accepted produce no output.
module sobel_edge_binarize #(
  parameter int WORD_SIZE = 8,
  parameter int ROW_SIZE  = 10,
  parameter int COL_SIZE  = 10,
  parameter int BORDER    = 1,
  localparam int CW       = $clog2(ROW_SIZE*COL_SIZE+1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] inputPixel,
  input  logic                 inputValid,
  input  logic                 frameStart,
  input  logic [WORD_SIZE-1:0] threshold,
  output logic [WORD_SIZE-1:0] outputPixel,
  output logic                 outputValid,
  output logic                 frameDone,
  output logic [CW-1:0]        edgeCount,
  output logic                 fsm_state
);

  localparam int CLW = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
  localparam int RW  = (COL_SIZE > 1) ? $clog2(COL_SIZE) : 1;

  typedef enum logic {WAIT_SOF = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                 state;
  logic [CLW-1:0]         col;
  logic [RW-1:0]          row;
  logic [WORD_SIZE-1:0]   thr_shadow;

  logic                   sof;
  logic                   accept;
  logic [CLW-1:0]         cur_col;
  logic [RW-1:0]          cur_row;
  logic [WORD_SIZE-1:0]   thr_eff;
  logic                   border;
  logic                   hit;
  logic                   last;

  // Debug view of the FSM: 0 = WAIT_SOF, 1 = ACTIVE.
  assign fsm_state = (state == ACTIVE);

  // Position, threshold and classification of the pixel on the input this
  // cycle. A frame-start pixel is always (0,0) and is compared against the
  // live threshold input, because the shadow only loads at this edge.
  always_comb begin
    sof     = inputValid && frameStart;
    accept  = inputValid && (frameStart || (state == ACTIVE));
    cur_col = sof ? '0 : col;
    cur_row = sof ? '0 : row;
    thr_eff = sof ? threshold : thr_shadow;
    border  = (32'(cur_row) < BORDER) || (32'(cur_row) >= COL_SIZE - BORDER) ||
              (32'(cur_col) < BORDER) || (32'(cur_col) >= ROW_SIZE - BORDER);
    hit     = !border && (inputPixel >= thr_eff);
    last    = (32'(cur_row) == COL_SIZE - 1) && (32'(cur_col) == ROW_SIZE - 1);
  end

  // FSM, raster counters, threshold shadow and the registered output stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= WAIT_SOF;
      col         <= '0;
      row         <= '0;
      thr_shadow  <= '0;
      outputPixel <= '0;
      outputValid <= 1'b0;
      frameDone   <= 1'b0;
    end else if (accept) begin
      outputValid <= 1'b1;
      outputPixel <= hit ? {WORD_SIZE{1'b1}} : '0;
      frameDone   <= last;
      if (sof) begin
        thr_shadow <= threshold;
      end
      if (last) begin
        col   <= '0;
        row   <= '0;
        state <= WAIT_SOF;
      end else begin
        state <= ACTIVE;
        if (32'(cur_col) == ROW_SIZE - 1) begin
          col <= '0;
          row <= cur_row + RW'(1);
        end else begin
          col <= cur_col + CLW'(1);
          row <= cur_row;
        end
      end
    end else begin
      outputValid <= 1'b0;
      outputPixel <= '0;
      frameDone   <= 1'b0;
    end
  end

`ifdef SOBEL_EDGE_COUNT_EN
  logic [CW-1:0] acc;
  logic [CW-1:0] acc_next;

  // Running count for the current frame; restarts at the frame-start pixel.
  always_comb begin
    acc_next = (sof ? '0 : acc) + CW'(hit);
  end

  // Accumulate edge pixels; publish the total with the last pixel. An
  // aborted frame never reaches its last pixel, so edgeCount keeps its value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      edgeCount <= '0;
    end else if (accept) begin
      if (last) begin
        edgeCount <= acc_next;
        acc       <= '0;
      end else begin
        acc <= acc_next;
      end
    end
  end
`else
  assign edgeCount = '0;
`endif

endmodule

// File: tb/tb_sobel_edge_binarize.sv
// Directed bench for sobel_edge_binarize on a 4x4 frame with a 1-pixel
// border. Interior pixels are raster indices 5, 6, 9 and 10.
module tb_sobel_edge_binarize;

  localparam int W  = 8;
  localparam int CW = $clog2(4*4+1);

  logic          clock;
  logic          reset;
  logic [W-1:0]  inputPixel;
  logic          inputValid;
  logic          frameStart;
  logic [W-1:0]  threshold;
  logic [W-1:0]  outputPixel;
  logic          outputValid;
  logic          frameDone;
  logic [CW-1:0] edgeCount;
  logic          fsm_state;

  int tests_run = 0;
  int failures  = 0;

  sobel_edge_binarize #(
    .WORD_SIZE(W), .ROW_SIZE(4), .COL_SIZE(4), .BORDER(1)
  ) dut (
    .clock(clock), .reset(reset), .inputPixel(inputPixel),
    .inputValid(inputValid), .frameStart(frameStart), .threshold(threshold),
    .outputPixel(outputPixel), .outputValid(outputValid),
    .frameDone(frameDone), .edgeCount(edgeCount), .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic is_int(input int idx);
    return (idx == 5) || (idx == 6) || (idx == 9) || (idx == 10);
  endfunction

  // edgeCount only carries a count when the accumulator is built.
  function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef SOBEL_EDGE_COUNT_EN
    return CW'(n);
`else
    return CW'(0 * n);
`endif
  endfunction

  // Driver: apply inputs at the falling edge, return 1 time unit after the
  // following rising edge, when the registered result is visible.
  task automatic drive(input logic [W-1:0] p, input logic fs, input logic v,
                       input logic [W-1:0] thr);
    @(negedge clock);
    inputPixel = p;
    frameStart = fs;
    inputValid = v;
    threshold  = thr;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (outputValid !== 1'b0 || outputPixel !== 8'h00 || frameDone !== 1'b0 ||
        edgeCount !== '0 || fsm_state !== 1'b0) begin
      failures++;
      $display("FAIL reset: valid=%b pix=%h done=%b cnt=%0d st=%b, need 0/00/0/0/0",
               outputValid, outputPixel, frameDone, edgeCount, fsm_state);
    end
  endtask

  // All-0xFF frame: only the four interior pixels survive.
  task automatic test_full_frame(input string tag);
    logic [W-1:0] e;
    for (int i = 0; i < 16; i++) begin
      drive(8'hFF, i == 0, 1'b1, 8'h80);
      e = is_int(i) ? 8'hFF : 8'h00;
      tests_run++;
      if (outputValid !== 1'b1 || outputPixel !== e || frameDone !== (i == 15)) begin
        failures++;
        $display("FAIL %s px%0d: valid=%b pix=%h done=%b, need 1/%h/%b",
                 tag, i, outputValid, outputPixel, frameDone, e, i == 15);
      end
    end
    drive(8'h00, 1'b0, 1'b0, 8'h80);
    tests_run++;
    if (outputValid !== 1'b0 || frameDone !== 1'b0 || edgeCount !== exp_cnt(4) ||
        fsm_state !== 1'b0) begin
      failures++;
      $display("FAIL %s end: valid=%b done=%b cnt=%0d st=%b, need 0/0/%0d/0",
               tag, outputValid, frameDone, edgeCount, fsm_state, exp_cnt(4));
    end
  endtask

  // Interior values around the threshold; border pixels 0xFF stay masked.
  task automatic test_threshold_levels();
    logic [W-1:0] p, e;
    for (int i = 0; i < 16; i++) begin
      case (i)
        5:       begin p = 8'h7F; e = 8'h00; end
        6:       begin p = 8'h80; e = 8'hFF; end
        9:       begin p = 8'h81; e = 8'hFF; end
        10:      begin p = 8'h00; e = 8'h00; end
        default: begin p = 8'hFF; e = 8'h00; end
      endcase
      drive(p, i == 0, 1'b1, 8'h80);
      tests_run++;
      if (outputValid !== 1'b1 || outputPixel !== e || frameDone !== (i == 15)) begin
        failures++;
        $display("FAIL levels px%0d: valid=%b pix=%h done=%b, need 1/%h/%b",
                 i, outputValid, outputPixel, frameDone, e, i == 15);
      end
    end
    drive(8'h00, 1'b0, 1'b0, 8'h80);
    tests_run++;
    if (edgeCount !== exp_cnt(2)) begin
      failures++;
      $display("FAIL levels count: got %0d need %0d", edgeCount, exp_cnt(2));
    end
  endtask

  // Pixels before any frame start are dropped; bubbles inside a frame hold
  // the position counters.
  task automatic test_no_sof_and_bubbles();
    logic [W-1:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(8'hFF, 1'b0, 1'b1, 8'h80);
      tests_run++;
      if (outputValid !== 1'b0 || fsm_state !== 1'b0) begin
        failures++;
        $display("FAIL no_sof %0d: valid=%b st=%b, need 0/0", i, outputValid, fsm_state);
      end
    end
    for (int i = 0; i < 16; i++) begin
      drive(8'hFF, i == 0, 1'b1, 8'h80);
      e = is_int(i) ? 8'hFF : 8'h00;
      tests_run++;
      if (outputValid !== 1'b1 || outputPixel !== e || frameDone !== (i == 15)) begin
        failures++;
        $display("FAIL bubbles px%0d: valid=%b pix=%h done=%b, need 1/%h/%b",
                 i, outputValid, outputPixel, frameDone, e, i == 15);
      end
      if (i % 3 == 1) begin
        drive(8'hFF, 1'b1, 1'b0, 8'h80);
        tests_run++;
        if (outputValid !== 1'b0 || frameDone !== 1'b0) begin
          failures++;
          $display("FAIL bubble after px%0d: valid=%b done=%b, need 0/0",
                   i, outputValid, frameDone);
        end
      end
    end
  endtask

  // Threshold drops mid-frame: current frame keeps 0x80, next uses 0x10.
  task automatic test_threshold_change();
    logic [W-1:0] p, e;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 16; i++) begin
        p = is_int(i) ? 8'h20 : 8'hFF;
        e = (f == 1 && is_int(i)) ? 8'hFF : 8'h00;
        drive(p, i == 0, 1'b1, (f == 0 && i < 5) ? 8'h80 : 8'h10);
        tests_run++;
        if (outputValid !== 1'b1 || outputPixel !== e || frameDone !== (i == 15)) begin
          failures++;
          $display("FAIL thr_change f%0d px%0d: valid=%b pix=%h done=%b, need 1/%h/%b",
                   f, i, outputValid, outputPixel, frameDone, e, i == 15);
        end
      end
      drive(8'h00, 1'b0, 1'b0, 8'h10);
      tests_run++;
      if (edgeCount !== exp_cnt(f == 0 ? 0 : 4)) begin
        failures++;
        $display("FAIL thr_change f%0d count: got %0d need %0d",
                 f, edgeCount, exp_cnt(f == 0 ? 0 : 4));
      end
    end
  endtask

  // frameStart at pixel 9 aborts; the restarted frame then runs to the end.
  task automatic test_abort();
    logic [W-1:0] p, e;
    for (int i = 0; i < 9; i++) begin
      drive(8'hFF, i == 0, 1'b1, 8'h80);
      e = is_int(i) ? 8'hFF : 8'h00;
      tests_run++;
      if (outputValid !== 1'b1 || outputPixel !== e || frameDone !== 1'b0 ||
          edgeCount !== exp_cnt(4)) begin
        failures++;
        $display("FAIL abort pre px%0d: valid=%b pix=%h done=%b cnt=%0d, need 1/%h/0/%0d",
                 i, outputValid, outputPixel, frameDone, edgeCount, e, exp_cnt(4));
      end
    end
    for (int i = 0; i < 16; i++) begin
      p = (i == 10) ? 8'h00 : 8'hFF;
      e = (is_int(i) && i != 10) ? 8'hFF : 8'h00;
      drive(p, i == 0, 1'b1, 8'h80);
      tests_run++;
      if (outputValid !== 1'b1 || outputPixel !== e || frameDone !== (i == 15) ||
          (i < 15 && edgeCount !== exp_cnt(4))) begin
        failures++;
        $display("FAIL abort post px%0d: valid=%b pix=%h done=%b cnt=%0d, need 1/%h/%b",
                 i, outputValid, outputPixel, frameDone, edgeCount, e, i == 15);
      end
    end
    tests_run++;
    if (edgeCount !== exp_cnt(3) || fsm_state !== 1'b0) begin
      failures++;
      $display("FAIL abort count: cnt=%0d st=%b, need %0d/0", edgeCount, fsm_state, exp_cnt(3));
    end
  endtask

  // Reset asserted between clock edges in the middle of a frame.
  task automatic test_async_reset();
    for (int i = 0; i < 6; i++) drive(8'hFF, i == 0, 1'b1, 8'h80);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (outputValid !== 1'b0 || outputPixel !== 8'h00 || frameDone !== 1'b0 ||
        edgeCount !== '0 || fsm_state !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: valid=%b pix=%h done=%b cnt=%0d st=%b, need 0/00/0/0/0",
               outputValid, outputPixel, frameDone, edgeCount, fsm_state);
    end
    inputValid = 1'b0;
    frameStart = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(8'hFF, 1'b0, 1'b1, 8'h80);
    tests_run++;
    if (outputValid !== 1'b0) begin
      failures++;
      $display("FAIL async_reset resync: valid=%b need 0", outputValid);
    end
    test_full_frame("after_reset");
  endtask

  initial begin
    reset      = 1'b0;
    inputPixel = '0;
    inputValid = 1'b0;
    frameStart = 1'b0;
    threshold  = '0;
    repeat (3) @(posedge clock);
    #1;
    test_reset();
    @(negedge clock);
    reset = 1'b1;
    test_full_frame("full_frame");
    test_threshold_levels();
    test_no_sof_and_bubbles();
    test_threshold_change();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
